// File: rtl/rr_hold_arbiter_if.sv
// rtl/rr_hold_arbiter_if.sv - request/grant bundle between requesters and the round-robin hold arbiter
interface rr_hold_arbiter_if #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
);
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            busy;
    logic [ID_W-1:0] ptr;

    modport master (output req, input grant, input grant_id, input busy, input ptr);
    modport slave  (input req, output grant, output grant_id, output busy, output ptr);
endinterface

// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - round-robin arbiter with grant hold limit; RR_HOLD_ARB_NOGAP_EN enables gapless handoff
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    rr_hold_arbiter_if.slave arb
);
    localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ID_W:0]   sel;
    logic [ID_W-1:0] next_ptr;
    logic            keep;

    // Returns {valid, index}: lowest request at or above p, else lowest request overall.
    function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
        logic [ID_W:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) res = {1'b1, ID_W'(i)};
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i] && (ID_W'(i) >= p)) res = {1'b1, ID_W'(i)};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sel      = rr_pick(arb.req, ptr_q);
        next_ptr = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
        keep     = arb.req[owner_q] && ((MAX_HOLD == 0) || (cnt_q < HOLD_LIM));
    end

`ifdef RR_HOLD_ARB_NOGAP_EN
    logic [ID_W:0] hand;
    always_comb begin
        hand = rr_pick(arb.req & ~(N'(1) << owner_q), next_ptr);
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel[ID_W]) begin
                    state_d = GRANT;
                    owner_d = sel[ID_W-1:0];
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                if (keep) begin
                    // Saturate so an unlimited hold never wraps the counter.
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end else begin
                    ptr_d = next_ptr;
`ifdef RR_HOLD_ARB_NOGAP_EN
                    if (hand[ID_W]) begin
                        owner_d = hand[ID_W-1:0];
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
`else
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end
            end
        endcase
    end

    always_comb begin
        arb.grant    = '0;
        arb.grant_id = '0;
        arb.busy     = 1'b0;
        arb.ptr      = ptr_q;
        if (state_q == GRANT) begin
            arb.grant[owner_q] = 1'b1;
            arb.grant_id       = owner_q;
            arb.busy           = 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb/tb_rr_hold_arbiter.sv - self-checking bench for rr_hold_arbiter (MAX_HOLD=1 and MAX_HOLD=8 instances)
module tb_rr_hold_arbiter;
    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int VW   = N + 2 * ID_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_hold_arbiter_if #(.N(N), .ID_W(ID_W)) if0 ();
    rr_hold_arbiter_if #(.N(N), .ID_W(ID_W)) if1 ();

    rr_hold_arbiter #(.N(N), .MAX_HOLD(1), .ID_W(ID_W)) dut0 (.clk(clk), .rst(rst), .arb(if0.slave));
    rr_hold_arbiter #(.N(N), .MAX_HOLD(8), .ID_W(ID_W)) dut1 (.clk(clk), .rst(rst), .arb(if1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner[2];
    int m_cnt[2];
    int m_ptr[2];
    int mh[2];
    logic [N-1:0] req_r;

    task automatic drive(input logic [N-1:0] r);
        req_r   = r;
        if0.req = r;
        if1.req = r;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_owner[k] = -1; m_cnt[k] = 0; m_ptr[k] = 0;
            end else if (m_owner[k] < 0) begin
                int s;
                s = pick(req_r, m_ptr[k]);
                if (s >= 0) begin m_owner[k] = s; m_cnt[k] = 1; end
            end else if (req_r[m_owner[k]] && (mh[k] == 0 || m_cnt[k] < mh[k])) begin
                m_cnt[k] = m_cnt[k] + 1;
            end else begin
                int np;
                int s;
                np = (m_owner[k] + 1) % N;
                m_ptr[k] = np;
                s = -1;
`ifdef RR_HOLD_ARB_NOGAP_EN
                s = pick(req_r & ~(N'(1) << m_owner[k]), np);
`endif
                if (s >= 0) begin m_owner[k] = s; m_cnt[k] = 1; end
                else begin m_owner[k] = -1; m_cnt[k] = 0; end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] obs(input int k);
        if (k == 0) return {if0.grant, if0.grant_id, if0.busy, if0.ptr};
        return {if1.grant, if1.grant_id, if1.busy, if1.ptr};
    endfunction

    function automatic logic [VW-1:0] mexp(input int k);
        logic [N-1:0]    g;
        logic [ID_W-1:0] gid;
        g   = (m_owner[k] >= 0) ? (N'(1) << m_owner[k]) : '0;
        gid = (m_owner[k] >= 0) ? ID_W'(m_owner[k]) : '0;
        return {g, gid, (m_owner[k] >= 0), ID_W'(m_ptr[k])};
    endfunction

    task automatic do_reset();
        drive('0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1111);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({if0.grant, if0.busy, if0.ptr, if1.grant, if1.busy, if1.ptr} !== '0) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: got g0=%b b0=%b p0=%0d g1=%b b1=%b p1=%0d required all zero",
                         c, if0.grant, if0.busy, if0.ptr, if1.grant, if1.busy, if1.ptr);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (if0.grant !== 4'b0001 || if1.grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release_grant: got %b/%b required 0001", if0.grant, if1.grant);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g_tab[9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        int           p_tab[9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
        do_reset();
        drive(4'b1111);
        for (int c = 0; c < 9; c++) begin
            tick();
            n_checks++;
            if (if0.grant !== g_tab[c] || if0.ptr !== ID_W'(p_tab[c])) begin
                n_fail++;
                $display("FAIL rr_hold1 cycle %0d: got grant=%b ptr=%0d required grant=%b ptr=%0d",
                         c, if0.grant, if0.ptr, g_tab[c], p_tab[c]);
            end
            n_checks++;
            if (obs(1) !== mexp(1)) begin
                n_fail++;
                $display("FAIL rr_model_inst1 cycle %0d: got %h required %h", c, obs(1), mexp(1));
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [N-1:0] g_exp;
        do_reset();
        drive(4'b0100);
        for (int c = 1; c <= 20; c++) begin
            tick();
            g_exp = (((c - 1) % 9) < 8) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (if1.grant !== g_exp || if1.grant_id !== ((g_exp != 0) ? 2'd2 : 2'd0)) begin
                n_fail++;
                $display("FAIL hold_limit cycle %0d: got grant=%b id=%0d required grant=%b", c, if1.grant, if1.grant_id, g_exp);
            end
            if (c == 9) begin
                n_checks++;
                if (if1.ptr !== 2'd3 || if1.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_release_ptr: got ptr=%0d busy=%b required ptr=3 busy=0", if1.ptr, if1.busy);
                end
            end
            n_checks++;
            if (obs(0) !== mexp(0)) begin
                n_fail++;
                $display("FAIL hold_model_inst0 cycle %0d: got %h required %h", c, obs(0), mexp(0));
            end
        end
    endtask

    task automatic test_wrap_fallback();
        do_reset();
        drive(4'b0100);
        tick();
        drive(4'b0000);
        tick();
        n_checks++;
        if (if1.ptr !== 2'd3 || if0.ptr !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_setup_ptr: got %0d/%0d required 3", if0.ptr, if1.ptr);
        end
        drive(4'b0011);
        tick();
        n_checks++;
        if (if1.grant !== 4'b0001 || if0.grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_grant: got %b/%b required 0001", if0.grant, if1.grant);
        end
        drive(4'b0000);
        tick();
        n_checks++;
        if (if1.ptr !== 2'd1 || if1.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL wrap_ptr_after: got ptr=%0d grant=%b required ptr=1 grant=0000", if1.ptr, if1.grant);
        end
    endtask

    task automatic test_early_release();
        logic [N-1:0] g_exp[7];
        g_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000};
`ifdef RR_HOLD_ARB_NOGAP_EN
        g_exp[4] = 4'b1000;
`endif
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(((c <= 3) ? 4'b0010 : 4'b0000) | ((c >= 2) ? 4'b1000 : 4'b0000));
            tick();
            n_checks++;
            if (if1.grant !== g_exp[c]) begin
                n_fail++;
                $display("FAIL early_release cycle %0d: got %b required %b", c + 1, if1.grant, g_exp[c]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        drive(4'b0100);
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (if1.grant !== 4'b0000 || if1.ptr !== 2'd0 || if1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_grant: got grant=%b ptr=%0d busy=%b required 0000/0/0", if1.grant, if1.ptr, if1.busy);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (if1.grant !== 4'b0100 || if1.grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL regrant_after_reset: got grant=%b id=%0d required 0100/2", if1.grant, if1.grant_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        do_reset();
        r = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) r = N'($urandom);
            drive(r);
            rst = ($urandom_range(63) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs(k) !== mexp(k)) begin
                    n_fail++;
                    $display("FAIL random_model inst%0d cycle %0d: got %h required %h", k, c, obs(k), mexp(k));
                end
            end
            n_checks++;
            if ($countones(if1.grant) > 1 || (if1.busy && if1.grant[if1.grant_id] !== 1'b1)) begin
                n_fail++;
                $display("FAIL random_onehot cycle %0d: got grant=%b id=%0d busy=%b required one-hot matching id",
                         c, if1.grant, if1.grant_id, if1.busy);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        mh[0] = 1;
        mh[1] = 8;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_cnt[k] = 0; m_ptr[k] = 0;
        end
        drive('0);
        test_reset();
        test_round_robin();
        test_hold_limit();
        test_wrap_fallback();
        test_early_release();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter with grant hold for up to N requesters sharing one resource.
- Rotating pointer masks the request vector; the masked request is served first, and the unmasked request is the fallback when the masked set is empty.
- A granted requester keeps ownership while its request stays high, up to a hold limit; the pointer then advances past the owner.
- Sits in front of the shared datapath and drives its select and enable.

Parameters:
N, 4, number of requesters (2..16)
MAX_HOLD, 8, max consecutive grant cycles per ownership; 0 = unlimited
ID_W, $clog2(N), width of grant_id and ptr

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req  in  N  request vector, level-sensitive, bit i = requester i
grant  out  N  one-hot registered grant; all-zero when idle
grant_id  out  ID_W  index of current owner; 0 when idle
busy  out  1  high while any grant bit is high
ptr  out  ID_W  current round-robin pointer (highest-priority index)

Behaviour:
- Reset: grant=0, grant_id=0, busy=0, ptr=0, hold count=0, FSM=IDLE. Reset mid-ownership drops grant on the next edge with no release handshake.
- Selection, combinational from req and ptr:
  - mask[i] = (i >= ptr).
  - If (req & mask) != 0, pick the lowest set index of req & mask.
  - Otherwise pick the lowest set index of req (wrap-around).
  - req = 0 means no selection.
- FSM IDLE:
  - Any req high in cycle t: grant = onehot(sel), grant_id = sel, busy = 1 from cycle t+1 (latency 1).
  - Hold count loads 1. Go to GRANT.
- FSM GRANT, owner o:
  - req[o] high and (MAX_HOLD == 0 or count < MAX_HOLD): hold grant, count += 1.
  - req[o] low: release.
  - MAX_HOLD != 0 and count == MAX_HOLD: forced release, even if req[o] is still high.
  - Release in cycle t: grant=0, busy=0 at t+1; ptr <= (o+1) mod N at t+1; FSM=IDLE. A new grant appears at t+2 at the earliest (1-cycle gap).
- Requests from non-owners never preempt the owner.
- Grant is one-hot or zero in every cycle; grant_id matches grant.
- Requests dropping in IDLE before being sampled are ignored; no request memory.
- MAX_HOLD == 1: every grant lasts exactly 1 cycle, then the pointer advances.
- Counter width is clog2(MAX_HOLD+1); it saturates and does not wrap when MAX_HOLD == 0.
- ptr wraps from N-1 to 0.
- Sole persistent requester with a forced release: it is re-granted after the 1-cycle gap; ptr still advances.

Optional Feature:
- Macro: RR_HOLD_ARB_NOGAP_EN.
- Defined:
  - On release in cycle t, selection is re-evaluated in the same cycle using ptr_next = (o+1) mod N and req masked to exclude o.
  - If the result is non-zero, grant moves directly to the new owner at t+1 (no idle cycle), count=1, ptr=ptr_next, busy stays 1.
  - If the result is zero, behaviour is the default release.
- Undefined: 1-cycle gap after every release, as above.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0, busy=0, ptr=0 throughout; rst falls at t -> grant=4'b0001 at t+1.
- Round robin, MAX_HOLD=1: req=4'b1111 held -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; ptr = 1,2,3,0.
- Hold limit, MAX_HOLD=8: req=4'b0100 held 20 cycles -> grant=0100 for exactly 8 cycles, 1 idle cycle, re-granted; ptr=3 after the first release.
- Wrap fallback: ptr=3 (established via prior grant to 2), req=4'b0011 -> grant=0001 (lowest unmasked), then ptr=1.
- Early release and no preemption: owner 1 holds; req[3] rises at cycle 2; req[1] falls at cycle 4 -> grant=0010 through cycle 4, 0 at cycle 5, 1000 at cycle 6; with RR_HOLD_ARB_NOGAP_EN, grant=1000 at cycle 5.
- Reset mid-grant: owner 2 at count 5, rst pulsed 1 cycle -> grant=0, ptr=0, count=0 next edge; req=4'b0100 still high -> re-granted 1 cycle after rst deasserts.
